pc_pipe_tracker: RTL and testbench
==================================

Name: pc_pipe_tracker

Overview:
- Parametrised PC delay line for the fetch path.
- Carries each fetched PC, with a valid bit, through DEPTH register stages so it reaches decode aligned with the instruction from a DEPTH-cycle-latency instruction memory (MAR + MDR + optional output regs).
- Adds stall, flush and jump-redirect handling, plus an in-flight count.
- Sits between the PC generator and the decode stage.

Parameters:
- PC_WIDTH, 32, width of every PC value.
- DEPTH, 2, number of delay stages; must equal instruction-memory read latency; legal range 1..8; any other value is an elaboration error.
- RESET_PC, 0, value loaded into every stage PC on reset.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  asynchronous active-high reset.
- pc_i  in  PC_WIDTH  PC issued to instruction memory this cycle.
- pc_i_valid  in  1  pc_i is a real fetch (0 = bubble).
- stall  in  1  freeze all stages (memory output also held).
- flush  in  1  squash everything in flight.
- pc_jump  in  1  redirect; pc_target replaces in-flight state.
- pc_target  in  PC_WIDTH  redirect PC.
- pc_o  out  PC_WIDTH  PC aligned with the instruction at decode.
- pc_o_valid  out  1  pc_o/instruction pair is valid.
- stage_valid  out  DEPTH  valid bit of each stage; bit 0 is the youngest.
- inflight  out  clog2(DEPTH+1)  count of set bits in stage_valid.

Behaviour:
- Storage is DEPTH stages, each holding {valid, pc}. Stage DEPTH-1 drives pc_o and pc_o_valid directly, with no combinational path from inputs.
- Reset (asynchronous, any time, including mid-stall or mid-jump):
  - all stage pc = RESET_PC, all valid = 0.
  - pc_o = RESET_PC, pc_o_valid = 0, stage_valid = 0, inflight = 0.
  - First capture happens on the first rising edge after rst deasserts.
- Each rising edge applies the first matching condition, in this priority:
  1. flush: all valid cleared, pc fields unchanged. pc_jump, stall and pc_i are ignored that cycle.
  2. pc_jump:
     - stage DEPTH-1 loads {1, pc_target}.
     - all other stages are cleared to valid = 0 (wrong-path squash).
     - Applies even when stall = 1.
     - For DEPTH=1 this is exactly "pc_o <= pc_target next edge".
  3. stall: all stages hold; pc_i is dropped (the PC generator must also hold).
  4. normal shift: stage k loads stage k-1 for k = 1..DEPTH-1; stage 0 loads {pc_i_valid, pc_i}.
- Latency: a valid pc_i sampled at edge n appears on pc_o after edge n+DEPTH-1, i.e. DEPTH edges, provided no stall, flush or jump occurs. Each stall cycle adds exactly 1 cycle.
- Bubbles (pc_i_valid = 0) travel through with pc_o_valid = 0. Their pc value still shifts, so they are distinguishable only by the valid bit.
- inflight is registered and updated on the same edge as the stages. It is never greater than DEPTH and never wraps.
- pc_o must not glitch combinationally; all outputs are flop outputs.
- Back-to-back jumps: each edge with pc_jump reloads stage DEPTH-1 from the new pc_target.
- Jump and flush asserted together: the flush wins, and no target is loaded.

Decomposition:
- Package pc_pipe_pkg:
  - typedef pc_t = logic [PC_WIDTH-1:0];
  - struct pc_stage_t {valid, pc};
  - DEPTH_MAX = 8;
  - function popcount for inflight.
- One sub-module, pc_pipe_stage: a single {valid, pc} register with async reset and three controls:
  - hold
  - clear
  - load {valid, pc}
- The top instantiates DEPTH copies in a generate loop and adds the priority decode and the inflight counter.

Test Plan:
- Reset/latency, DEPTH=2:
  - Stimulus: rst high for 3 cycles, then pc_i = 0x00, 0x04, 0x08 on consecutive edges with valid = 1.
  - Response: pc_o_valid = 0 during reset; pc_o = 0x00, 0x04, 0x08 on the 2nd, 3rd and 4th edges after release; inflight goes 1, 2, 2.
- Stall:
  - Stimulus: stream 0x10, 0x14, 0x18 with stall = 1 for 2 cycles after 0x14 enters.
  - Response: stage contents frozen for those 2 cycles; pc_o sequence 0x10, 0x10, 0x10, 0x14, 0x18, with no PC lost or duplicated beyond the stall hold.
- Jump:
  - Stimulus: stages hold 0x20 and 0x24, then pc_jump = 1 with pc_target = 0x100.
  - Response: next edge pc_o = 0x100 with valid = 1; stage 0 valid = 0; inflight = 1. Repeat with stall = 1 and expect the same result.
- Flush vs jump:
  - Stimulus: flush = 1 and pc_jump = 1 in the same cycle, target 0x200.
  - Response: all stage_valid = 0; inflight = 0; pc_o_valid = 0; 0x200 never appears on pc_o.
- Bubbles, DEPTH=3:
  - Stimulus: pc_i_valid pattern 1, 0, 1 with PCs 0x30, 0x34, 0x38.
  - Response: pc_o_valid pattern 1, 0, 1 starting 3 edges later; inflight never exceeds 2.
- Async reset mid-stream, DEPTH=4:
  - Stimulus: assert rst between clock edges while inflight = 4.
  - Response: outputs go to RESET_PC/0 immediately, without waiting for a clock edge; stream resumes with correct 4-edge latency after release.

Source files
------------

// File: rtl/pc_pipe_pkg.sv
// pc_pipe_pkg
// Shared types, limits and helpers for the fetch-path PC delay line.
//   pc_t        : PC value at the default datapath width
//   pc_stage_t  : one delay stage, {valid, pc}
//   DEPTH_MAX   : deepest instruction-memory latency the tracker supports
//   popcount    : number of set bits in a stage-valid vector
package pc_pipe_pkg;

  localparam int PC_WIDTH_DEFAULT = 32;
  localparam int DEPTH_MAX        = 8;

  typedef logic [PC_WIDTH_DEFAULT-1:0] pc_t;

  typedef struct packed {
    logic valid;
    pc_t  pc;
  } pc_stage_t;

  // Counts the live entries of a stage-valid vector padded out to DEPTH_MAX.
  function automatic logic [3:0] popcount(input logic [DEPTH_MAX-1:0] bits);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH_MAX; i++) begin
      cnt = cnt + {3'b000, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pc_pipe_stage.sv
// pc_pipe_stage
// One {valid, pc} register of the PC delay line.
//   clk, rst      : clock and asynchronous active-high reset
//   hold_i        : keep current contents
//   clear_i       : drop the valid bit, pc field untouched (wins over hold/load)
//   load_valid_i  : valid bit captured when neither clear nor hold
//   load_pc_i     : pc captured when neither clear nor hold
//   valid_o, pc_o : registered stage contents
module pc_pipe_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold_i,
  input  logic                clear_i,
  input  logic                load_valid_i,
  input  logic [PC_WIDTH-1:0] load_pc_i,
  output logic                valid_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_q;

  // Clear only kills the valid bit so a squashed slot keeps its last PC;
  // otherwise the stage either holds or takes whatever the top steers in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      valid_q <= load_valid_i;
      pc_q    <= load_pc_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_pipe_tracker.sv
// pc_pipe_tracker
// Delays each fetched PC by DEPTH cycles so it reaches decode together with
// the instruction from a DEPTH-cycle instruction memory, with flush, jump
// redirect and stall handling.
//   clk, rst          : clock and asynchronous active-high reset
//   pc_i, pc_i_valid  : PC issued to instruction memory and its valid bit
//   stall             : freeze all stages
//   flush             : squash everything in flight (highest priority)
//   pc_jump, pc_target: redirect; target lands directly in the last stage
//   pc_o, pc_o_valid  : PC aligned with the instruction at decode
//   stage_valid       : per-stage valid bits, bit 0 youngest
//   inflight          : registered count of set bits in stage_valid
module pc_pipe_tracker
  import pc_pipe_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_WIDTH_DEFAULT,
  parameter int                  DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PC_WIDTH-1:0]          pc_i,
  input  logic                         pc_i_valid,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         pc_jump,
  input  logic [PC_WIDTH-1:0]          pc_target,
  output logic [PC_WIDTH-1:0]          pc_o,
  output logic                         pc_o_valid,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   inflight
);

  localparam int IW = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : gBadDepth
    $error("pc_pipe_tracker: DEPTH must be in 1..8");
  end

  logic [DEPTH-1:0]    stageValid;
  logic [PC_WIDTH-1:0] stagePc [DEPTH];
  logic [DEPTH-1:0]    nextValid;
  logic                doJump;
  logic                holdAll;
  logic [IW-1:0]       inflight_q;
  logic [IW-1:0]       inflight_d;

  // Priority: flush > jump > stall > shift. Jump overrides stall.
  assign doJump  = pc_jump & ~flush;
  assign holdAll = stall & ~flush & ~pc_jump;

  for (genvar k = 0; k < DEPTH; k++) begin : gStage
    logic                shValid;
    logic [PC_WIDTH-1:0] shPc;
    logic                ldValid;
    logic [PC_WIDTH-1:0] ldPc;
    logic                clr;

    if (k == 0) begin : gHead
      assign shValid = pc_i_valid;
      assign shPc    = pc_i;
    end else begin : gBody
      assign shValid = stageValid[k-1];
      assign shPc    = stagePc[k-1];
    end

    // The oldest stage takes the redirect target; younger stages hold
    // wrong-path fetches and are squashed on a jump.
    if (k == DEPTH - 1) begin : gTail
      assign ldValid = doJump | shValid;
      assign ldPc    = doJump ? pc_target : shPc;
      assign clr     = flush;
    end else begin : gMid
      assign ldValid = shValid;
      assign ldPc    = shPc;
      assign clr     = flush | pc_jump;
    end

    // Mirror of the stage update, used only to keep inflight registered
    // in step with the stages.
    assign nextValid[k] = clr ? 1'b0 : (holdAll ? stageValid[k] : ldValid);

    pc_pipe_stage #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC)
    ) uStage (
      .clk          (clk),
      .rst          (rst),
      .hold_i       (holdAll),
      .clear_i      (clr),
      .load_valid_i (ldValid),
      .load_pc_i    (ldPc),
      .valid_o      (stageValid[k]),
      .pc_o         (stagePc[k])
    );
  end

  // Next inflight count is the popcount of the next stage-valid vector.
  always_comb begin
    logic [DEPTH_MAX-1:0] validPad;
    validPad               = '0;
    validPad[DEPTH-1:0]    = nextValid;
    inflight_d             = IW'(popcount(validPad));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign pc_o        = stagePc[DEPTH-1];
  assign pc_o_valid  = stageValid[DEPTH-1];
  assign stage_valid = stageValid;
  assign inflight    = inflight_q;

endmodule

// File: tb/tb_pc_pipe_tracker.sv
// tb_pc_pipe_tracker
// Directed bench driving DEPTH=2, 3 and 4 trackers from one shared stimulus
// stream; each scenario checks the instance whose depth it targets.
module tb_pc_pipe_tracker;

  logic        clk;
  logic        rst;
  logic [31:0] pcIn;
  logic        pcInValid;
  logic        stallIn;
  logic        flushIn;
  logic        jumpIn;
  logic [31:0] targetIn;

  logic [31:0] pc2, pc3, pc4;
  logic        v2, v3, v4;
  logic [1:0]  sv2;
  logic [2:0]  sv3;
  logic [3:0]  sv4;
  logic [1:0]  if2, if3;
  logic [2:0]  if4;

  int checkCount;
  int failCount;

  localparam logic [31:0] RESET_PC4 = 32'h0000_FFFC;

  pc_pipe_tracker #(.PC_WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) u2 (
    .clk(clk), .rst(rst), .pc_i(pcIn), .pc_i_valid(pcInValid),
    .stall(stallIn), .flush(flushIn), .pc_jump(jumpIn), .pc_target(targetIn),
    .pc_o(pc2), .pc_o_valid(v2), .stage_valid(sv2), .inflight(if2));

  pc_pipe_tracker #(.PC_WIDTH(32), .DEPTH(3), .RESET_PC(32'h0)) u3 (
    .clk(clk), .rst(rst), .pc_i(pcIn), .pc_i_valid(pcInValid),
    .stall(stallIn), .flush(flushIn), .pc_jump(jumpIn), .pc_target(targetIn),
    .pc_o(pc3), .pc_o_valid(v3), .stage_valid(sv3), .inflight(if3));

  pc_pipe_tracker #(.PC_WIDTH(32), .DEPTH(4), .RESET_PC(RESET_PC4)) u4 (
    .clk(clk), .rst(rst), .pc_i(pcIn), .pc_i_valid(pcInValid),
    .stall(stallIn), .flush(flushIn), .pc_jump(jumpIn), .pc_target(targetIn),
    .pc_o(pc4), .pc_o_valid(v4), .stage_valid(sv4), .inflight(if4));

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 unit after the rising edge.
  task automatic applyStimulus(input logic [31:0] pcVal, input logic vld,
                               input logic stl, input logic fl,
                               input logic jmp, input logic [31:0] tgt);
    pcIn      = pcVal;
    pcInValid = vld;
    stallIn   = stl;
    flushIn   = fl;
    jumpIn    = jmp;
    targetIn  = tgt;
    @(posedge clk);
    #1;
  endtask

  // Scenario sequence; pipeline state carries from one scenario to the next.
  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    pcIn       = '0;
    pcInValid  = 1'b0;
    stallIn    = 1'b0;
    flushIn    = 1'b0;
    jumpIn     = 1'b0;
    targetIn   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_v2", v2, 0);
    checkOutput("rst_pc2", pc2, 0);
    checkOutput("rst_sv2", sv2, 0);
    checkOutput("rst_if2", if2, 0);
    checkOutput("rst_pc4", pc4, RESET_PC4);
    checkOutput("rst_if4", if4, 0);
    rst = 1'b0;

    // Latency, DEPTH=2
    applyStimulus(32'h00, 1, 0, 0, 0, 0);
    checkOutput("lat_e1_v", v2, 0);
    checkOutput("lat_e1_if", if2, 1);
    applyStimulus(32'h04, 1, 0, 0, 0, 0);
    checkOutput("lat_e2_pc", pc2, 32'h00);
    checkOutput("lat_e2_v", v2, 1);
    checkOutput("lat_e2_if", if2, 2);
    applyStimulus(32'h08, 1, 0, 0, 0, 0);
    checkOutput("lat_e3_pc", pc2, 32'h04);
    checkOutput("lat_e3_if", if2, 2);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("lat_e4_pc", pc2, 32'h08);
    checkOutput("lat_e4_v", v2, 1);
    checkOutput("lat_e4_if", if2, 1);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("lat_e5_v", v2, 0);
    checkOutput("lat_e5_if", if2, 0);

    // Stall, DEPTH=2
    applyStimulus(32'h10, 1, 0, 0, 0, 0);
    checkOutput("stl_a_v", v2, 0);
    applyStimulus(32'h14, 1, 0, 0, 0, 0);
    checkOutput("stl_b_pc", pc2, 32'h10);
    applyStimulus(32'h18, 1, 1, 0, 0, 0);
    checkOutput("stl_c_pc", pc2, 32'h10);
    checkOutput("stl_c_sv", sv2, 2'b11);
    applyStimulus(32'h18, 1, 1, 0, 0, 0);
    checkOutput("stl_d_pc", pc2, 32'h10);
    checkOutput("stl_d_if", if2, 2);
    applyStimulus(32'h18, 1, 0, 0, 0, 0);
    checkOutput("stl_e_pc", pc2, 32'h14);
    checkOutput("stl_e_v", v2, 1);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("stl_f_pc", pc2, 32'h18);
    checkOutput("stl_f_if", if2, 1);

    // Jump, DEPTH=2, then jump under stall
    applyStimulus(32'h20, 1, 0, 0, 0, 0);
    applyStimulus(32'h24, 1, 0, 0, 0, 0);
    checkOutput("jmp_pre_pc", pc2, 32'h20);
    applyStimulus(32'h28, 1, 0, 0, 1, 32'h100);
    checkOutput("jmp_pc", pc2, 32'h100);
    checkOutput("jmp_v", v2, 1);
    checkOutput("jmp_sv", sv2, 2'b10);
    checkOutput("jmp_if", if2, 1);
    applyStimulus(32'h20, 1, 0, 0, 0, 0);
    applyStimulus(32'h24, 1, 0, 0, 0, 0);
    checkOutput("jmps_pre_pc", pc2, 32'h20);
    checkOutput("jmps_pre_sv", sv2, 2'b11);
    applyStimulus(32'h28, 1, 1, 0, 1, 32'h100);
    checkOutput("jmps_pc", pc2, 32'h100);
    checkOutput("jmps_v", v2, 1);
    checkOutput("jmps_sv", sv2, 2'b10);
    checkOutput("jmps_if", if2, 1);

    // Flush beats jump, DEPTH=2
    applyStimulus(32'h40, 1, 0, 0, 0, 0);
    applyStimulus(32'h44, 1, 0, 0, 0, 0);
    checkOutput("fl_pre_if", if2, 2);
    applyStimulus(32'h48, 1, 0, 1, 1, 32'h200);
    checkOutput("fl_sv", sv2, 0);
    checkOutput("fl_if", if2, 0);
    checkOutput("fl_v", v2, 0);
    checkOutput("fl_pc", pc2, 32'h40);
    checkOutput("fl_if4", if4, 0);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("fl_next_pc", pc2, 32'h44);
    checkOutput("fl_next_v", v2, 0);

    // Bubbles, DEPTH=3
    applyStimulus(32'h30, 1, 0, 0, 0, 0);
    checkOutput("bub_e1_if", if3, 1);
    applyStimulus(32'h34, 0, 0, 0, 0, 0);
    checkOutput("bub_e2_if", if3, 1);
    checkOutput("bub_e2_v", v3, 0);
    applyStimulus(32'h38, 1, 0, 0, 0, 0);
    checkOutput("bub_e3_pc", pc3, 32'h30);
    checkOutput("bub_e3_v", v3, 1);
    checkOutput("bub_e3_sv", sv3, 3'b101);
    checkOutput("bub_e3_if", if3, 2);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("bub_e4_pc", pc3, 32'h34);
    checkOutput("bub_e4_v", v3, 0);
    checkOutput("bub_e4_if", if3, 1);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("bub_e5_pc", pc3, 32'h38);
    checkOutput("bub_e5_v", v3, 1);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("bub_e6_v", v3, 0);
    checkOutput("bub_e6_if", if3, 0);

    // Async reset mid-stream, DEPTH=4
    applyStimulus(32'h50, 1, 0, 0, 0, 0);
    applyStimulus(32'h54, 1, 0, 0, 0, 0);
    applyStimulus(32'h58, 1, 0, 0, 0, 0);
    applyStimulus(32'h5C, 1, 0, 0, 0, 0);
    checkOutput("ar_full_if", if4, 4);
    checkOutput("ar_full_pc", pc4, 32'h50);
    checkOutput("ar_full_sv", sv4, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_pc", pc4, RESET_PC4);
    checkOutput("ar_v", v4, 0);
    checkOutput("ar_sv", sv4, 0);
    checkOutput("ar_if", if4, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(32'h60, 1, 0, 0, 0, 0);
    checkOutput("ar_r1_v", v4, 0);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("ar_r2_v", v4, 0);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("ar_r3_v", v4, 0);
    applyStimulus(32'h00, 0, 0, 0, 0, 0);
    checkOutput("ar_r4_pc", pc4, 32'h60);
    checkOutput("ar_r4_v", v4, 1);
    checkOutput("ar_r4_if", if4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
